// File: rtl/alu_ctrl_seq_pkg.sv
// Shared definitions for the ALU control sequencer: opcode mnemonics,
// control-class sub-ops, FSM states and decode select encodings.
package alu_ctrl_seq_pkg;

   typedef enum logic [2:0] {
      kADD = 3'd0,
      kLSH = 3'd1,
      kRSH = 3'd2,
      kXOR = 3'd3,
      kAND = 3'd4,
      kSUB = 3'd5,
      kOR  = 3'd6,
      kCTL = 3'd7
   } op_mne;

   // Idle value on the ALU opcode bus; the all-zero code keeps reset outputs at 0
   localparam op_mne kNOP = kADD;

   typedef enum logic [2:0] {
      kCLC  = 3'd0,
      kSEC  = 3'd1,
      kBZ   = 3'd2,
      kBNZ  = 3'd3,
      kHALT = 3'd7
   } ctl_sub_e;

   typedef enum logic [1:0] {IDLE, EXEC, WB, HALT} seq_state_e;

   typedef enum logic [1:0] {SC_ZERO, SC_CARRY, SC_ONE} sc_sel_e;

   typedef enum logic [1:0] {CY_KEEP, CY_ALU, CY_CLR, CY_SET} cy_src_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Fetch handshake, ALU and register-file signals of the sequencer.
// The sequencer uses the slave modport; master is the surrounding datapath.
interface alu_ctrl_seq_if #(
   parameter int IW  = 9,
   parameter int RAW = 3
);
   logic [IW-1:0]  INSTR_IN;
   logic           INSTR_VALID;
   logic           INSTR_READY;
   logic [2:0]     ALU_OP;
   logic           ALU_SC_IN;
   logic           ALU_SC_OUT;
   logic           ALU_ZERO;
   logic [RAW-1:0] RF_RADDR_A;
   logic [RAW-1:0] RF_RADDR_B;
   logic [RAW-1:0] RF_WADDR;
   logic           RF_WEN;
   logic           BRANCH_TAKEN;
   logic           CARRY_FLAG;
   logic           ZERO_FLAG;
   logic           HALTED;

   modport master (
      output INSTR_IN, INSTR_VALID, ALU_SC_OUT, ALU_ZERO,
      input  INSTR_READY, ALU_OP, ALU_SC_IN, RF_RADDR_A, RF_RADDR_B,
             RF_WADDR, RF_WEN, BRANCH_TAKEN, CARRY_FLAG, ZERO_FLAG, HALTED
   );

   modport slave (
      input  INSTR_IN, INSTR_VALID, ALU_SC_OUT, ALU_ZERO,
      output INSTR_READY, ALU_OP, ALU_SC_IN, RF_RADDR_A, RF_RADDR_B,
             RF_WADDR, RF_WEN, BRANCH_TAKEN, CARRY_FLAG, ZERO_FLAG, HALTED
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of the latched instruction into ALU opcode,
// carry-in select, flag-update controls and control-class actions.
module alu_ctrl_decode
   import alu_ctrl_seq_pkg::*;
#(
   parameter int IW = 9
) (
   input  logic [IW-1:0] ir,
   output op_mne         alu_op,
   output sc_sel_e       sc_sel,
   output cy_src_e       cy_src,
   output logic          zero_upd,
   output logic          rf_wen,
   output logic          is_bz,
   output logic          is_bnz,
   output logic          is_halt
);

   logic [2:0] opc;
   logic [2:0] sub;

   always_comb begin
      opc      = ir[IW-1 -: 3];
      sub      = ir[2:0];
      alu_op   = op_mne'(opc);
      sc_sel   = SC_ZERO;
      cy_src   = CY_KEEP;
      zero_upd = 1'b1;
      rf_wen   = 1'b1;
      is_bz    = 1'b0;
      is_bnz   = 1'b0;
      is_halt  = 1'b0;
      case (op_mne'(opc))
         kADD, kLSH, kRSH: begin
            sc_sel = SC_CARRY;
            cy_src = CY_ALU;
         end
         kSUB:             sc_sel = SC_ONE;
         kXOR, kAND, kOR:  cy_src = CY_CLR;
         default: begin
            // control class: ALU idle, no register write, zero flag untouched
            alu_op   = kNOP;
            zero_upd = 1'b0;
            rf_wen   = 1'b0;
            case (sub)
               kCLC:    cy_src  = CY_CLR;
               kSEC:    cy_src  = CY_SET;
               kBZ:     is_bz   = 1'b1;
               kBNZ:    is_bnz  = 1'b1;
               kHALT:   is_halt = 1'b1;
               default: ;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Three-cycle IDLE/EXEC/WB instruction sequencer driving the ALU and register
// file, holding the architectural carry/zero flags; HALT is terminal.
module alu_ctrl_seq
   import alu_ctrl_seq_pkg::*;
#(
   parameter int IW  = 9,
   parameter int RAW = 3
) (
   input logic          CLK,
   input logic          RST_N,
   alu_ctrl_seq_if.slave bus
);

   seq_state_e    state, next_state;
   logic [IW-1:0] ir;
   logic          ready_q;
   logic          carry_q, zero_q;
   logic          sc_smp, z_smp;
   logic          accept;

   op_mne   dec_op;
   sc_sel_e dec_sc;
   cy_src_e dec_cy;
   logic    dec_zupd, dec_wen, dec_bz, dec_bnz, dec_halt;

   alu_ctrl_decode #(.IW(IW)) u_decode (
      .ir       (ir),
      .alu_op   (dec_op),
      .sc_sel   (dec_sc),
      .cy_src   (dec_cy),
      .zero_upd (dec_zupd),
      .rf_wen   (dec_wen),
      .is_bz    (dec_bz),
      .is_bnz   (dec_bnz),
      .is_halt  (dec_halt)
   );

   assign accept = ready_q && bus.INSTR_VALID;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = EXEC;
         EXEC:    next_state = WB;
         WB:      next_state = dec_halt ? HALT : IDLE;
         default: next_state = HALT;
      endcase
   end

   // Ready is registered so it stays low in reset and rises one edge after release
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ir      <= '0;
         ready_q <= 1'b0;
         sc_smp  <= 1'b0;
         z_smp   <= 1'b0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         ready_q <= (next_state == IDLE);
         if (accept) ir <= bus.INSTR_IN;
         if (state == EXEC) begin
            sc_smp <= bus.ALU_SC_OUT;
            z_smp  <= bus.ALU_ZERO;
         end
         if (state == WB) begin
            case (dec_cy)
               CY_ALU:  carry_q <= sc_smp;
               CY_CLR:  carry_q <= 1'b0;
               CY_SET:  carry_q <= 1'b1;
               default: ;
            endcase
            if (dec_zupd) zero_q <= z_smp;
         end
      end
   end

   always_comb begin
      bus.ALU_SC_IN = 1'b0;
      if (state == EXEC) begin
         case (dec_sc)
            SC_CARRY: bus.ALU_SC_IN = carry_q;
            SC_ONE:   bus.ALU_SC_IN = 1'b1;
            default:  bus.ALU_SC_IN = 1'b0;
         endcase
      end
   end

   assign bus.INSTR_READY  = ready_q;
   assign bus.ALU_OP       = (state == EXEC) ? dec_op : kNOP;
   assign bus.RF_RADDR_A   = ir[RAW +: RAW];
   assign bus.RF_RADDR_B   = ir[RAW-1:0];
   assign bus.RF_WADDR     = ir[RAW +: RAW];
   assign bus.RF_WEN       = (state == WB) && dec_wen;
   assign bus.BRANCH_TAKEN = (state == WB) && ((dec_bz && zero_q) || (dec_bnz && !zero_q));
   assign bus.CARRY_FLAG   = carry_q;
   assign bus.ZERO_FLAG    = zero_q;
   assign bus.HALTED       = (state == HALT);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus random
// instructions compared against an architectural flag/behaviour model.
module tb_alu_ctrl_seq;

   logic CLK   = 1'b0;
   logic RST_N = 1'b1;

   alu_ctrl_seq_if #(.IW(9), .RAW(3)) bus ();

   alu_ctrl_seq #(.IW(9), .RAW(3)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // architectural model state
   bit m_carry, m_zero, m_halt;

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle();
      check1("idle_ready",  bus.INSTR_READY,  !m_halt);
      check1("idle_halted", bus.HALTED,       m_halt);
      check1("idle_carry",  bus.CARRY_FLAG,   m_carry);
      check1("idle_zero",   bus.ZERO_FLAG,    m_zero);
      check1("idle_wen",    bus.RF_WEN,       1'b0);
      check1("idle_branch", bus.BRANCH_TAKEN, 1'b0);
   endtask

   task automatic check_cleared(input string tag);
      check1({tag, "_ready"},  bus.INSTR_READY,  1'b0);
      check1({tag, "_halted"}, bus.HALTED,       1'b0);
      check1({tag, "_carry"},  bus.CARRY_FLAG,   1'b0);
      check1({tag, "_zero"},   bus.ZERO_FLAG,    1'b0);
      check1({tag, "_wen"},    bus.RF_WEN,       1'b0);
      check1({tag, "_branch"}, bus.BRANCH_TAKEN, 1'b0);
      check1({tag, "_scin"},   bus.ALU_SC_IN,    1'b0);
      check3({tag, "_aluop"},  bus.ALU_OP,       3'd0);
      check3({tag, "_raddra"}, bus.RF_RADDR_A,   3'd0);
      check3({tag, "_raddrb"}, bus.RF_RADDR_B,   3'd0);
   endtask

   // Called at a falling edge in an IDLE cycle; returns at the falling edge
   // of the IDLE cycle following write-back.
   task automatic do_instr(input logic [8:0] ins, input bit sc, input bit z);
      logic [2:0] opc, rd, rb, exp_op;
      bit exp_sc, exp_wen, exp_br, n_carry, n_zero;
      opc = ins[8:6];
      rd  = ins[5:3];
      rb  = ins[2:0];

      exp_op  = (opc == 3'd7) ? 3'd0 : opc;
      exp_sc  = (opc <= 3'd2) ? m_carry : (opc == 3'd5);
      exp_wen = (opc != 3'd7);
      exp_br  = (opc == 3'd7) && ((rb == 3'd2 && m_zero) || (rb == 3'd3 && !m_zero));
      n_carry = m_carry;
      n_zero  = m_zero;
      if (opc <= 3'd2)                      n_carry = sc;
      else if (opc inside {3'd3, 3'd4, 3'd6}) n_carry = 1'b0;
      else if (opc == 3'd7 && rb == 3'd0)   n_carry = 1'b0;
      else if (opc == 3'd7 && rb == 3'd1)   n_carry = 1'b1;
      if (opc != 3'd7) n_zero = z;

      bus.INSTR_IN    = ins;
      bus.INSTR_VALID = 1'b1;
      @(negedge CLK);
      bus.INSTR_VALID = 1'b0;
      bus.INSTR_IN    = 9'($urandom);
      check1("exec_ready",  bus.INSTR_READY,  1'b0);
      check3("exec_aluop",  bus.ALU_OP,       exp_op);
      check1("exec_scin",   bus.ALU_SC_IN,    exp_sc);
      check3("exec_raddra", bus.RF_RADDR_A,   rd);
      check3("exec_raddrb", bus.RF_RADDR_B,   rb);
      check1("exec_wen",    bus.RF_WEN,       1'b0);
      check1("exec_branch", bus.BRANCH_TAKEN, 1'b0);
      bus.ALU_SC_OUT = sc;
      bus.ALU_ZERO   = z;
      @(negedge CLK);
      bus.ALU_SC_OUT = 1'($urandom);
      bus.ALU_ZERO   = 1'($urandom);
      check1("wb_ready",  bus.INSTR_READY,  1'b0);
      check1("wb_wen",    bus.RF_WEN,       exp_wen);
      if (exp_wen) check3("wb_waddr", bus.RF_WADDR, rd);
      check1("wb_branch", bus.BRANCH_TAKEN, exp_br);
      check1("wb_carry",  bus.CARRY_FLAG,   m_carry);
      check1("wb_zero",   bus.ZERO_FLAG,    m_zero);
      m_carry = n_carry;
      m_zero  = n_zero;
      m_halt  = (opc == 3'd7) && (rb == 3'd7);
      @(negedge CLK);
      check_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_q[$];
      int wen_cnt;
      logic [8:0] ins;
      logic [2:0] opc, sub;

      bus.INSTR_IN    = '0;
      bus.INSTR_VALID = 1'b0;
      bus.ALU_SC_OUT  = 1'b0;
      bus.ALU_ZERO    = 1'b0;

      // power-on reset
      #1 RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      check_cleared("rst");
      RST_N = 1'b1;
      m_carry = 1'b0; m_zero = 1'b0; m_halt = 1'b0;
      #1 check1("rel_ready_low", bus.INSTR_READY, 1'b0);
      @(negedge CLK);
      check1("rel_ready_high", bus.INSTR_READY, 1'b1);

      // ADD r1,r2 producing carry
      do_instr(9'b000_001_010, 1'b1, 1'b0);
      // SEC, ADD, SUB, XOR carry-in and carry-flag behaviour
      do_instr(9'b111_000_001, 1'b0, 1'b0);
      do_instr(9'b000_011_100, 1'b1, 1'b0);
      do_instr(9'b101_010_011, 1'b0, 1'b1);
      do_instr(9'b011_110_101, 1'b1, 1'b0);
      // XOR with zero result, then BZ / BNZ
      do_instr(9'b011_001_001, 1'b0, 1'b1);
      do_instr(9'b111_000_010, 1'b0, 1'b0);
      do_instr(9'b111_000_011, 1'b0, 1'b0);
      // CLC after SEC
      do_instr(9'b111_000_001, 1'b0, 1'b0);
      do_instr(9'b111_000_000, 1'b0, 1'b0);

      // VALID held high: accepts every third cycle
      bus.ALU_ZERO    = 1'b0;
      bus.INSTR_VALID = 1'b1;
      wen_cnt = 0;
      for (int c = 0; c < 14; c++) begin
         if (acc_q.size() == 4) bus.INSTR_VALID = 1'b0;
         bus.INSTR_IN   = {3'd3, 3'(c), 3'(c + 1)};
         bus.ALU_SC_OUT = 1'($urandom);
         if (bus.RF_WEN) wen_cnt++;
         if (bus.INSTR_READY && bus.INSTR_VALID) acc_q.push_back(c);
         @(negedge CLK);
      end
      bus.INSTR_VALID = 1'b0;
      check_int("stream_accepts", acc_q.size(), 4);
      for (int i = 0; i < 4 && i < acc_q.size(); i++)
         check_int("stream_accept_cycle", acc_q[i], 3 * i);
      check_int("stream_wen_pulses", wen_cnt, 4);
      m_carry = 1'b0;
      m_zero  = 1'b0;
      check_idle();

      // random instructions (HALT excluded)
      for (int i = 0; i < 40; i++) begin
         opc = 3'($urandom);
         sub = 3'($urandom);
         if (opc == 3'd7 && sub == 3'd7) sub = 3'd6;
         ins = {opc, 3'($urandom), sub};
         do_instr(ins, 1'($urandom), 1'($urandom));
      end

      // asynchronous reset during EXEC of an ADD
      do_instr(9'b111_000_001, 1'b0, 1'b0);
      bus.INSTR_IN    = 9'b000_011_100;
      bus.INSTR_VALID = 1'b1;
      @(negedge CLK);
      bus.INSTR_VALID = 1'b0;
      bus.ALU_SC_OUT  = 1'b0;
      check1("pre_rst_carry",  bus.CARRY_FLAG,  1'b1);
      check3("pre_rst_raddra", bus.RF_RADDR_A,  3'd3);
      #2 RST_N = 1'b0;
      #1 check_cleared("mid_rst");
      @(negedge CLK);
      RST_N = 1'b1;
      m_carry = 1'b0; m_zero = 1'b0; m_halt = 1'b0;
      wen_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         if (bus.RF_WEN) wen_cnt++;
      end
      check_int("mid_rst_no_wen", wen_cnt, 0);
      check_idle();

      // HALT is terminal with VALID held high
      do_instr(9'b111_000_001, 1'b0, 1'b0);
      do_instr(9'b111_000_111, 1'b0, 1'b0);
      bus.INSTR_VALID = 1'b1;
      for (int c = 0; c < 10; c++) begin
         bus.INSTR_IN = {3'd0, 6'($urandom)};
         @(negedge CLK);
         check1("halt_halted", bus.HALTED,       1'b1);
         check1("halt_ready",  bus.INSTR_READY,  1'b0);
         check1("halt_wen",    bus.RF_WEN,       1'b0);
         check1("halt_branch", bus.BRANCH_TAKEN, 1'b0);
      end
      #2 RST_N = 1'b0;
      #1 check_cleared("halt_rst");
      @(negedge CLK);
      RST_N = 1'b1;
      bus.INSTR_VALID = 1'b0;
      m_carry = 1'b0; m_zero = 1'b0; m_halt = 1'b0;
      @(negedge CLK);
      check_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Multi-cycle control sequencer that drives the combinational ALU's opcode/carry-in interface and consumes its carry-out and zero outputs.
- Accepts one 9-bit instruction per handshake from the fetch stage, decodes it and issues the ALU operation.
- Holds the architectural carry and zero flags, drives register-file addresses and write enable, and signals branches and halt.
- Sits between fetch/PC logic and the ALU/register-file datapath.

Parameters:
- IW, 9, instruction width; opcode in bits [IW-1:IW-3].
- RAW, 3, register-file address width.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- INSTR_IN  in  9  instruction: [8:6] opcode, [5:3] rd/ra, [2:0] rb/sub-op
- INSTR_VALID  in  1  fetch offers INSTR_IN
- INSTR_READY  out  1  sequencer can accept; transfer when VALID&&READY
- ALU_OP  out  3  opcode to ALU
- ALU_SC_IN  out  1  carry/shift-in to ALU
- ALU_SC_OUT  in  1  ALU carry/shift-out
- ALU_ZERO  in  1  ALU zero flag
- RF_RADDR_A  out  3  read port A address (= rd)
- RF_RADDR_B  out  3  read port B address (= rb)
- RF_WADDR  out  3  write address (= rd)
- RF_WEN  out  1  register write strobe, one cycle
- BRANCH_TAKEN  out  1  one-cycle pulse, PC loads target
- CARRY_FLAG  out  1  architectural carry
- ZERO_FLAG  out  1  architectural zero
- HALTED  out  1  sequencer stopped

Behaviour:
- Reset (async, RST_N=0):
  - State to IDLE; instruction register, flags and all outputs to 0.
  - INSTR_READY rises in the first cycle after release.
  - Reset mid-instruction aborts it with no RF_WEN and no flag update.
- States: IDLE -> EXEC -> WB -> IDLE; HALT is terminal until reset.
- IDLE:
  - INSTR_READY=1.
  - On VALID&&READY, latch INSTR_IN and go to EXEC.
  - Without VALID, stay in IDLE.
- EXEC:
  - INSTR_READY=0.
  - Drive ALU_OP=opcode, RF_RADDR_A=rd, RF_RADDR_B=rb.
  - Sample ALU_SC_OUT and ALU_ZERO at the end of the cycle.
- WB:
  - Opcodes 0..6: RF_WEN=1, RF_WADDR=rd; flag registers updated on the WB edge (visible the cycle after WB); then go to IDLE.
  - Throughput is one instruction per 3 cycles; an instruction accepted at edge N has RF_WEN high in cycle N+2.
- ALU_SC_IN rules:
  - kADD, kLSH, kRSH: ALU_SC_IN=CARRY_FLAG.
  - kSUB: ALU_SC_IN=1 (A+~B+1, two's complement).
  - Other ops: 0.
- Flag rules:
  - kADD, kLSH, kRSH: CARRY_FLAG<=ALU_SC_OUT.
  - kSUB: CARRY_FLAG unchanged.
  - kXOR, kAND, kOR: CARRY_FLAG<=0.
  - ZERO_FLAG<=ALU_ZERO for all opcodes 0..6.
- Opcode 3'b111 (control class): no ALU use; ALU_OP=kNOP; no RF_WEN. Sub-op in [2:0]:
  - 000 CLC: CARRY_FLAG<=0 at WB.
  - 001 SEC: CARRY_FLAG<=1 at WB.
  - 010 BZ: BRANCH_TAKEN=1 in WB iff ZERO_FLAG=1.
  - 011 BNZ: BRANCH_TAKEN=1 in WB iff ZERO_FLAG=0.
  - 111 HALT: enter HALT after WB.
  - Others: no-op.
- HALT: INSTR_READY=0, HALTED=1, all strobes 0; INSTR_VALID ignored.
- Outputs are registered or decoded from state and the instruction register only; INSTR_IN and INSTR_VALID have no combinational path to outputs.
- INSTR_IN changing while not accepted has no effect.

Decomposition:
- Shared package (definitions) holds:
  - op_mne enum: kADD=0, kLSH=1, kRSH=2, kXOR=3, kAND=4, kSUB=5, kOR=6, kCTL=7, plus kNOP alias for the ALU default.
  - ctl_sub_e enum: CLC, SEC, BZ, BNZ, HALT.
  - seq_state_e enum: IDLE, EXEC, WB, HALT.
- One sub-module, alu_ctrl_decode: combinational decode of the latched instruction into ALU_OP, SC_IN select and flag-update enables.
- FSM and flag registers stay in alu_ctrl_seq.

Test Plan:
- Reset then ADD r1,r2 with ALU_SC_OUT=1, ALU_ZERO=0 -> INSTR_READY low 2 cycles; RF_WEN=1, RF_WADDR=1 in cycle N+2; CARRY_FLAG=1, ZERO_FLAG=0 afterwards.
- SEC then ADD -> ALU_SC_IN=1 during the ADD EXEC; then SUB -> ALU_SC_IN=1 and CARRY_FLAG unchanged; then XOR -> CARRY_FLAG=0.
- XOR with ALU_ZERO=1, then BZ -> BRANCH_TAKEN pulses exactly one cycle; then BNZ -> no pulse, no RF_WEN.
- INSTR_VALID held high continuously with 4 instructions -> accepts at cycles 0, 3, 6, 9; exactly 4 RF_WEN pulses.
- HALT (9'b111_000_111) -> HALTED=1, INSTR_READY=0 with VALID high for 10 cycles; RST_N pulse returns to IDLE with all flags 0.
- RST_N asserted asynchronously mid-cycle during EXEC of an ADD -> outputs clear immediately with no clock edge; no RF_WEN; flags 0.
